// File: rtl/iir_pkg.sv
// Shared types and sizing helpers for the time-multiplexed IIR filter.
package iir_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      CAPTURE,
      MAC,
      WRITE,
      DONE
   } state_e;

   localparam int B_BASE = 0;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

   // Headroom covers the 2N+1 full-scale products plus the rounding preload.
   function automatic int acc_w(input int data_w, input int coef_w, input int order);
      return data_w + coef_w + clog2(2 * order + 1) + 1;
   endfunction

   function automatic int a_base(input int order);
      return order + 1;
   endfunction

endpackage

// File: rtl/iir_mac_unit.sv
// Signed multiply-accumulate with rounding preload, add/subtract select and
// a saturating, rounded output at DATA_W bits.
module iir_mac_unit
   import iir_pkg::*;
#(
   parameter int DATA_W    = 16,
   parameter int COEF_W    = 20,
   parameter int COEF_FRAC = 16,
   parameter int ACC_W     = 41
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     preload,
   input  logic                     en,
   input  logic                     sub,
   input  logic signed [COEF_W-1:0] coef,
   input  logic signed [DATA_W-1:0] sample,
   output logic signed [DATA_W-1:0] result,
   output logic                     saturated
);

   localparam int PROD_W = DATA_W + COEF_W;
   localparam logic signed [ACC_W-1:0] ROUND_K = ACC_W'(1) << (COEF_FRAC - 1);
   localparam logic signed [ACC_W-1:0] Y_MAX   = (ACC_W'(1) << (DATA_W - 1)) - ACC_W'(1);
   localparam logic signed [ACC_W-1:0] Y_MIN   = ~Y_MAX;

   logic signed [ACC_W-1:0]  acc_q, acc_d;
   logic signed [PROD_W-1:0] product;
   logic signed [ACC_W-1:0]  shifted;

   assign product = coef * sample;

   // NOTE: every signal written here gets a value before any branch, so no latch is inferred.
   always_comb begin
      acc_d = acc_q;
      if (preload) begin
         acc_d = ROUND_K;
      end else if (en) begin
         acc_d = sub ? acc_q - ACC_W'(product) : acc_q + ACC_W'(product);
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops update together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) acc_q <= '0;
      else     acc_q <= acc_d;
   end

   always_comb begin
      shifted   = acc_q >>> COEF_FRAC;
      saturated = 1'b0;
      result    = shifted[DATA_W-1:0];
      if (shifted > Y_MAX) begin
         result    = Y_MAX[DATA_W-1:0];
         saturated = 1'b1;
      end else if (shifted < Y_MIN) begin
         result    = Y_MIN[DATA_W-1:0];
         saturated = 1'b1;
      end
   end

endmodule

// File: rtl/iir_mac_stream.sv
// Direct-form-I IIR streaming filter: fetches samples, runs one shared MAC over
// all 2N+1 taps, and writes one rounded/saturated result per sample.
module iir_mac_stream
   import iir_pkg::*;
#(
   parameter int DATA_W    = 16,
   parameter int COEF_W    = 20,
   parameter int COEF_FRAC = 16,
   parameter int ORDER     = 5,
   parameter int ADDR_W    = 20
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             start,
   input  logic                             coef_we,
   input  logic [clog2(2*ORDER+1)-1:0]      coef_addr,
   input  logic [COEF_W-1:0]                coef_wdata,
   output logic                             load,
   output logic [ADDR_W-1:0]                RAddr,
   input  logic [DATA_W-1:0]                DIn,
   input  logic                             data_done,
   output logic                             WEN,
   output logic [ADDR_W-1:0]                WAddr,
   output logic [DATA_W-1:0]                Yn,
   output logic                             busy,
   output logic                             sat,
   output logic                             Finish
);

   localparam int NCOEF  = 2 * ORDER + 1;
   localparam int TAP_W  = clog2(NCOEF);
   localparam int ACC_W  = acc_w(DATA_W, COEF_W, ORDER);
   localparam int A_BASE = a_base(ORDER);

   state_e                    state_q, state_d;
   logic [ADDR_W-1:0]         idx_q, idx_d;
   logic [TAP_W-1:0]          tap_q, tap_d;
   logic                      sat_q, sat_d;
   logic signed [DATA_W-1:0]  x_cur_q, x_cur_d;
   logic signed [DATA_W-1:0]  x_hist_q [1:ORDER];
   logic signed [DATA_W-1:0]  x_hist_d [1:ORDER];
   logic signed [DATA_W-1:0]  y_hist_q [1:ORDER];
   logic signed [DATA_W-1:0]  y_hist_d [1:ORDER];
   logic signed [COEF_W-1:0]  coef_q   [NCOEF];
   logic signed [COEF_W-1:0]  coef_d   [NCOEF];

   logic                      busy_w;
   logic                      mac_preload, mac_en, mac_sub, mac_sat;
   logic signed [COEF_W-1:0]  coef_op;
   logic signed [DATA_W-1:0]  data_op;
   logic signed [DATA_W-1:0]  mac_result;

   assign busy_w = (state_q != IDLE) && (state_q != DONE);

   // Tap order: b0*x[n], b1..bN*x[n-k], then a1..aN*y[n-k] subtracted.
   always_comb begin
      coef_op = '0;
      data_op = '0;
      mac_sub = 1'b0;
      for (int i = 0; i < NCOEF; i++) begin
         if (int'(tap_q) == i) coef_op = coef_q[i];
      end
      if (int'(tap_q) == B_BASE) data_op = x_cur_q;
      for (int k = 1; k <= ORDER; k++) begin
         if (int'(tap_q) == B_BASE + k) data_op = x_hist_q[k];
         if (int'(tap_q) == A_BASE + k - 1) begin
            data_op = y_hist_q[k];
            mac_sub = 1'b1;
         end
      end
   end

   iir_mac_unit #(
      .DATA_W    (DATA_W),
      .COEF_W    (COEF_W),
      .COEF_FRAC (COEF_FRAC),
      .ACC_W     (ACC_W)
   ) u_mac (
      .clk       (clk),
      .rst       (rst),
      .preload   (mac_preload),
      .en        (mac_en),
      .sub       (mac_sub),
      .coef      (coef_op),
      .sample    (data_op),
      .result    (mac_result),
      .saturated (mac_sat)
   );

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      tap_d       = tap_q;
      sat_d       = sat_q;
      x_cur_d     = x_cur_q;
      x_hist_d    = x_hist_q;
      y_hist_d    = y_hist_q;
      coef_d      = coef_q;
      mac_preload = 1'b0;
      mac_en      = 1'b0;
      load        = 1'b0;
      WEN         = 1'b0;
      Yn          = '0;

      // Applied in the same cycle as an accepted start, so the run sees it.
      if (coef_we && !busy_w) begin
         for (int i = 0; i < NCOEF; i++) begin
            if (int'(coef_addr) == i) coef_d[i] = coef_wdata;
         end
      end

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d = FETCH;
               idx_d   = '0;
               sat_d   = 1'b0;
               x_cur_d = '0;
               for (int k = 1; k <= ORDER; k++) begin
                  x_hist_d[k] = '0;
                  y_hist_d[k] = '0;
               end
            end
         end
         FETCH: begin
            load    = 1'b1;
            state_d = CAPTURE;
         end
         CAPTURE: begin
            if (data_done) begin
               state_d = DONE;
            end else begin
               x_cur_d     = DIn;
               tap_d       = '0;
               mac_preload = 1'b1;
               state_d     = MAC;
            end
         end
         MAC: begin
            mac_en = 1'b1;
            if (int'(tap_q) == NCOEF - 1) state_d = WRITE;
            else                          tap_d   = tap_q + TAP_W'(1);
         end
         WRITE: begin
            WEN         = 1'b1;
            Yn          = mac_result;
            x_hist_d[1] = x_cur_q;
            y_hist_d[1] = mac_result;
            for (int k = 2; k <= ORDER; k++) begin
               x_hist_d[k] = x_hist_q[k-1];
               y_hist_d[k] = y_hist_q[k-1];
            end
            if (mac_sat) sat_d = 1'b1;
            // The last address ends the run instead of wrapping onto index 0.
            if (&idx_q) begin
               state_d = DONE;
            end else begin
               idx_d   = idx_q + ADDR_W'(1);
               state_d = FETCH;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: the coefficient file is a register array with async reset, because
   // reset must leave every coefficient at zero; a RAM macro could not do that.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         tap_q   <= '0;
         sat_q   <= 1'b0;
         x_cur_q <= '0;
         for (int k = 1; k <= ORDER; k++) begin
            x_hist_q[k] <= '0;
            y_hist_q[k] <= '0;
         end
         for (int i = 0; i < NCOEF; i++) coef_q[i] <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         tap_q    <= tap_d;
         sat_q    <= sat_d;
         x_cur_q  <= x_cur_d;
         x_hist_q <= x_hist_d;
         y_hist_q <= y_hist_d;
         coef_q   <= coef_d;
      end
   end

   assign RAddr  = idx_q;
   assign WAddr  = idx_q;
   assign busy   = busy_w;
   assign sat    = sat_q;
   assign Finish = (state_q == DONE);

endmodule

// File: tb/tb_iir_mac_stream.sv
// Directed bench for iir_mac_stream: scoreboard of expected results, checked
// on every WEN, plus control/timing checks and a small-address wrap instance.
module tb_iir_mac_stream;

   typedef struct {
      int addr;
      int y;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        coef_we = 1'b0;
   logic [3:0]  coef_addr = '0;
   logic [19:0] coef_wdata = '0;
   logic        load, WEN, busy, sat, Finish;
   logic [19:0] RAddr, WAddr;
   logic [15:0] DIn = '0;
   logic        data_done = 1'b0;
   logic signed [15:0] Yn;

   logic        start_w = 1'b0;
   logic        load_w, wen_w, busy_w, sat_w, finish_w;
   logic [1:0]  raddr_w, waddr_w;
   logic [15:0] din_w = '0;
   logic        dd_w = 1'b0;
   logic signed [15:0] yn_w;

   int   mem [0:63];
   int   n_samples = 0;
   exp_t exp_q [$];
   int   n_cmp = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   last_load_cyc = 0, load_gap = 0;
   int   last_wen_cyc = 0, wen_gap = 0, wen_cnt = 0;
   int   wrap_cnt = 0;

   iir_mac_stream dut (
      .clk(clk), .rst(rst), .start(start), .coef_we(coef_we),
      .coef_addr(coef_addr), .coef_wdata(coef_wdata),
      .load(load), .RAddr(RAddr), .DIn(DIn), .data_done(data_done),
      .WEN(WEN), .WAddr(WAddr), .Yn(Yn),
      .busy(busy), .sat(sat), .Finish(Finish)
   );

   iir_mac_stream #(.ADDR_W(2)) u_wrap (
      .clk(clk), .rst(rst), .start(start_w), .coef_we(coef_we),
      .coef_addr(coef_addr), .coef_wdata(coef_wdata),
      .load(load_w), .RAddr(raddr_w), .DIn(din_w), .data_done(dd_w),
      .WEN(wen_w), .WAddr(waddr_w), .Yn(yn_w),
      .busy(busy_w), .sat(sat_w), .Finish(finish_w)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // Sample memories: registered read, data valid one cycle after load.
   always @(posedge clk) begin
      if (load) begin
         DIn       <= 16'(mem[RAddr[5:0]]);
         data_done <= (int'(RAddr) >= n_samples);
      end
      if (load_w) begin
         din_w <= 16'(int'(raddr_w) * 10 + 5);
         dd_w  <= 1'b0;
      end
   end

   task automatic check(input string tag, input logic signed [63:0] obs,
                        input logic signed [63:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   always @(negedge clk) begin
      if (load || WEN) check("load_wen_exclusive", 64'(load && WEN), 0);
      if (load) begin
         load_gap      = cyc - last_load_cyc;
         last_load_cyc = cyc;
      end
      if (WEN) begin
         wen_cnt++;
         wen_gap      = cyc - last_wen_cyc;
         last_wen_cyc = cyc;
         check("wen_expected", 64'(exp_q.size() > 0), 1);
         if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("waddr", WAddr, e.addr);
            check("yn", Yn, e.y);
         end
      end
      if (wen_w) begin
         wrap_cnt++;
         check("wrap_waddr", waddr_w, wrap_cnt - 1);
         check("wrap_yn", yn_w, (wrap_cnt - 1) * 10 + 5);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_coef(input int a, input int v);
      coef_we    = 1'b1;
      coef_addr  = 4'(a);
      coef_wdata = 20'(v);
      tick(1);
      coef_we    = 1'b0;
   endtask

   task automatic clear_coefs();
      for (int i = 0; i < 11; i++) set_coef(i, 0);
   endtask

   task automatic push(input int a, input int y);
      exp_t e;
      e.addr = a;
      e.y    = y;
      exp_q.push_back(e);
   endtask

   task automatic start_pulse(output int c0);
      start = 1'b1;
      c0    = cyc;
      tick(1);
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int i;
      i = 0;
      while (!Finish && i < budget) begin
         tick(1);
         i++;
      end
      check("done_in_time", Finish, 1);
      check("sb_drained", exp_q.size(), 0);
   endtask

   initial begin
      int c0, wen_base;
      longint b [0:5];
      longint a [1:5];
      longint xs [0:7];
      longint ys [0:7];
      longint acc;
      logic   exp_sat;

      // Reset state
      tick(3);
      check("rst_load", load, 0);
      check("rst_wen", WEN, 0);
      check("rst_busy", busy, 0);
      check("rst_sat", sat, 0);
      check("rst_finish", Finish, 0);
      check("rst_raddr", RAddr, 0);
      check("rst_waddr", WAddr, 0);
      check("rst_yn", Yn, 0);
      rst = 1'b0;
      tick(2);

      // 1: unity b0 passes samples through
      set_coef(0, 65536);
      mem[0] = 100; mem[1] = -7; mem[2] = 0; n_samples = 3;
      push(0, 100); push(1, -7); push(2, 0);
      start_pulse(c0);
      check("t1_busy", busy, 1);
      wait_done(100);
      check("t1_busy_done", busy, 0);
      check("t1_sat", sat, 0);

      // 2: one-pole lowpass, step input, round half up
      set_coef(0, 32768);
      set_coef(6, -32768);
      for (int i = 0; i < 4; i++) mem[i] = 1000;
      n_samples = 4;
      push(0, 500); push(1, 750); push(2, 875); push(3, 938);
      start_pulse(c0);
      wait_done(120);
      check("t2_sat", sat, 0);

      // 3: gain 2 saturates both ways; sat is sticky
      set_coef(6, 0);
      set_coef(0, 131072);
      mem[0] = 20000; mem[1] = -20000; n_samples = 2;
      push(0, 32767); push(1, -32768);
      start_pulse(c0);
      wait_done(80);
      check("t3_sat", sat, 1);
      tick(5);
      check("t3_sat_held", sat, 1);

      // 4: data_done on third read, timing of WEN and load
      set_coef(0, 65536);
      mem[0] = 11; mem[1] = 22; mem[2] = 33; n_samples = 2;
      push(0, 11); push(1, 22);
      wen_base = wen_cnt;
      start_pulse(c0);
      check("t4_sat_cleared", sat, 0);
      for (int i = 0; i < 40 && !WEN; i++) tick(1);
      check("t4_start_to_wen", cyc - c0, 14);
      wait_done(80);
      check("t4_wen_pulses", wen_cnt - wen_base, 2);
      check("t4_wen_period", wen_gap, 14);
      check("t4_load_period", load_gap, 14);
      tick(20);
      check("t4_finish_held", Finish, 1);

      // 5: reset during MAC of sample 1
      mem[0] = 100; mem[1] = -7; mem[2] = 0; n_samples = 3;
      push(0, 100); push(1, -7); push(2, 0);
      start_pulse(c0);
      tick(18);
      rst = 1'b1;
      @(negedge clk);
      check("t5_busy", busy, 0);
      check("t5_load", load, 0);
      check("t5_wen", WEN, 0);
      check("t5_finish", Finish, 0);
      check("t5_raddr", RAddr, 0);
      check("t5_yn", Yn, 0);
      check("t5_one_write_before_rst", exp_q.size(), 2);
      exp_q.delete();
      tick(3);
      rst = 1'b0;
      tick(1);
      push(0, 0); push(1, 0); push(2, 0);
      start_pulse(c0);
      wait_done(100);
      set_coef(0, 65536);
      push(0, 100); push(1, -7); push(2, 0);
      start_pulse(c0);
      wait_done(100);

      // 6: coef write while busy is ignored; with start in idle it applies
      push(0, 100); push(1, -7); push(2, 0);
      start_pulse(c0);
      tick(4);
      set_coef(0, 0);
      wait_done(100);
      push(0, 0); push(1, 0); push(2, 0);
      start = 1'b1; coef_we = 1'b1; coef_addr = 4'd0; coef_wdata = 20'd0;
      tick(1);
      start = 1'b0; coef_we = 1'b0;
      wait_done(100);

      // 7: all taps, random coefficients against a reference model
      for (int k = 0; k <= 5; k++) begin
         b[k] = longint'(int'($urandom_range(40000)) - 20000);
         set_coef(k, int'(b[k]));
      end
      for (int k = 1; k <= 5; k++) begin
         a[k] = longint'(int'($urandom_range(16000)) - 8000);
         set_coef(5 + k, int'(a[k]));
      end
      exp_sat = 1'b0;
      for (int n = 0; n < 8; n++) begin
         xs[n]  = longint'(int'($urandom_range(6000)) - 3000);
         mem[n] = int'(xs[n]);
         acc = 32768;
         for (int k = 0; k <= 5; k++) if (n - k >= 0) acc += b[k] * xs[n-k];
         for (int k = 1; k <= 5; k++) if (n - k >= 0) acc -= a[k] * ys[n-k];
         ys[n] = acc >>> 16;
         if (ys[n] > 32767)  begin ys[n] = 32767;  exp_sat = 1'b1; end
         if (ys[n] < -32768) begin ys[n] = -32768; exp_sat = 1'b1; end
         push(n, int'(ys[n]));
      end
      n_samples = 8;
      start_pulse(c0);
      wait_done(200);
      check("t7_sat", sat, 64'(exp_sat));

      // 8: 2-bit address instance stops after index 3 without data_done
      clear_coefs();
      set_coef(0, 65536);
      start_w = 1'b1;
      tick(1);
      start_w = 1'b0;
      for (int i = 0; i < 120 && !finish_w; i++) tick(1);
      check("wrap_finish", finish_w, 1);
      check("wrap_busy", busy_w, 0);
      check("wrap_count", wrap_cnt, 4);
      tick(30);
      check("wrap_no_extra", wrap_cnt, 4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
